// File: rtl/merge_sort_block_param.sv
// rtl/merge_sort_block_param.sv - block sorter: lane-parallel load, odd-even transposition sort, one-per-cycle drain
module merge_sort_block_param #(
    parameter int DATA_W  = 8,
    parameter int LANES   = 4,
    parameter int BLK_LEN = 32,
    parameter bit SIGNED  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      BlkIn,
    input  logic                      InValid,
    input  logic [LANES*DATA_W-1:0]   InData,
    input  logic                      Desc,
    output logic                      InReady,
    output logic [DATA_W-1:0]         SortOut,
    output logic                      OutValid,
    output logic                      OutLast,
    input  logic                      OutReady,
    output logic                      ErrDrop,
    output logic                      Busy
);
    localparam int BEATS = BLK_LEN / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IW    = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(BLK_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SORT, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [IW-1:0]     pass_q, pass_d;
    logic [IW-1:0]     rd_q, rd_d;
    logic              desc_q, desc_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] elem_q [BLK_LEN];
    logic [DATA_W-1:0] elem_d [BLK_LEN];

    // True when the pair (a,b) is in the wrong order for the latched direction; ties never swap.
    function automatic logic out_of_order(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                          input logic desc);
        logic gt, lt;
        if (SIGNED) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return desc ? lt : gt;
    endfunction

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        pass_d  = pass_q;
        rd_d    = rd_q;
        desc_d  = desc_q;
        err_d   = 1'b0;
        elem_d  = elem_q;
        case (state_q)
            S_IDLE: begin
                if (InValid) begin
                    if (BlkIn) begin
                        for (int k = 0; k < LANES; k++) elem_d[k] = InData[k*DATA_W +: DATA_W];
                        beat_d  = BW'(1);
                        desc_d  = Desc;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (InValid) begin
                    if (BlkIn) begin
                        // A new block start discards the partial block.
                        for (int k = 0; k < LANES; k++) elem_d[k] = InData[k*DATA_W +: DATA_W];
                        beat_d = BW'(1);
                        desc_d = Desc;
                        err_d  = 1'b1;
                    end else begin
                        for (int k = 0; k < LANES; k++)
                            elem_d[int'(beat_q)*LANES + k] = InData[k*DATA_W +: DATA_W];
                        beat_d = beat_q + 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            beat_d  = '0;
                            pass_d  = '0;
                            state_d = S_SORT;
                        end
                    end
                end
            end
            S_SORT: begin
                for (int i = 0; i < BLK_LEN - 1; i++) begin
                    if ((i % 2) == int'(pass_q[0]) && out_of_order(elem_q[i], elem_q[i+1], desc_q)) begin
                        elem_d[i]   = elem_q[i+1];
                        elem_d[i+1] = elem_q[i];
                    end
                end
                pass_d = pass_q + 1'b1;
                if (pass_q == LAST_IDX) begin
                    pass_d  = '0;
                    rd_d    = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (OutReady) begin
                    if (rd_q == LAST_IDX) begin
                        rd_d    = '0;
                        state_d = S_IDLE;
                    end else begin
                        rd_d = rd_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            pass_q  <= '0;
            rd_q    <= '0;
            desc_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            pass_q  <= pass_d;
            rd_q    <= rd_d;
            desc_q  <= desc_d;
            err_q   <= err_d;
        end
    end

    // Buffer contents after reset are never observable, so no reset is needed here.
    always_ff @(posedge clk) begin
        elem_q <= elem_d;
    end

    assign InReady  = !rst && (state_q == S_IDLE || state_q == S_LOAD);
    assign OutValid = (state_q == S_DRAIN);
    assign SortOut  = OutValid ? elem_q[rd_q] : '0;
    assign OutLast  = OutValid && (rd_q == LAST_IDX);
    assign ErrDrop  = err_q;
    assign Busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_merge_sort_block_param.sv
// tb/tb_merge_sort_block_param.sv - table, hand-sequence and random checks of signed and unsigned sorter instances
module tb_merge_sort_block_param;
    localparam int DW = 8;
    localparam int L  = 4;
    localparam int N  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, BlkIn, InValid, Desc, OutReady;
    logic [L*DW-1:0] InData;
    logic          s_InReady, s_OutValid, s_OutLast, s_ErrDrop, s_Busy;
    logic          u_InReady, u_OutValid, u_OutLast, u_ErrDrop, u_Busy;
    logic [DW-1:0] s_SortOut, u_SortOut;

    merge_sort_block_param #(.DATA_W(DW), .LANES(L), .BLK_LEN(N), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .BlkIn(BlkIn), .InValid(InValid), .InData(InData), .Desc(Desc),
        .InReady(s_InReady), .SortOut(s_SortOut), .OutValid(s_OutValid), .OutLast(s_OutLast),
        .OutReady(OutReady), .ErrDrop(s_ErrDrop), .Busy(s_Busy));

    merge_sort_block_param #(.DATA_W(DW), .LANES(L), .BLK_LEN(N), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .BlkIn(BlkIn), .InValid(InValid), .InData(InData), .Desc(Desc),
        .InReady(u_InReady), .SortOut(u_SortOut), .OutValid(u_OutValid), .OutLast(u_OutLast),
        .OutReady(OutReady), .ErrDrop(u_ErrDrop), .Busy(u_Busy));

    int checks = 0;
    int passed = 0;
    int err_s  = 0;
    int err_u  = 0;

    always @(negedge clk) begin
        if (s_ErrDrop === 1'b1) err_s++;
        if (u_ErrDrop === 1'b1) err_u++;
    end

    typedef struct packed {
        logic [63:0] v;
        logic        desc;
        logic [1:0]  mode;
        logic        junk;
        logic [63:0] es;
        logic [63:0] eu;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [63:0] pack8(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                          input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                                          input logic [7:0] b6, input logic [7:0] b7);
        return {b7, b6, b5, b4, b3, b2, b1, b0};
    endfunction

    // Reference: interpret elements as integers and selection-sort them.
    function automatic logic [63:0] model_sort(input logic [63:0] v, input logic desc, input bit sgn);
        int a [N];
        int t;
        logic [63:0] r;
        for (int i = 0; i < N; i++) a[i] = sgn ? int'($signed(v[i*8 +: 8])) : int'(v[i*8 +: 8]);
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++)
                if (desc ? (a[j] > a[i]) : (a[j] < a[i])) begin
                    t = a[i]; a[i] = a[j]; a[j] = t;
                end
        for (int i = 0; i < N; i++) r[i*8 +: 8] = 8'(a[i]);
        return r;
    endfunction

    task automatic send_beat(input logic blk, input logic [31:0] d, input logic desc);
        @(negedge clk);
        chk("in_ready", {30'd0, s_InReady, u_InReady}, 32'd3);
        InValid = 1'b1; BlkIn = blk; InData = d; Desc = desc;
        @(posedge clk); #1;
        InValid = 1'b0; BlkIn = 1'b0; Desc = 1'b0;
    endtask

    task automatic send_block(input logic [63:0] v, input logic desc);
        send_beat(1'b1, v[31:0], desc);
        send_beat(1'b0, v[63:32], ~desc);
    endtask

    task automatic wait_valid(input logic junk);
        int cnt;
        cnt = 0;
        while (cnt < 100) begin
            @(posedge clk); cnt++;
            @(negedge clk);
            if (cnt == 1) chk("sort_busy", {28'd0, s_Busy, s_InReady, u_Busy, u_InReady}, 32'hA);
            if (s_OutValid === 1'b1) break;
            if (junk) begin InValid = 1'b1; BlkIn = 1'b1; InData = $urandom; end
        end
        InValid = 1'b0; BlkIn = 1'b0;
        chk("latency", cnt, N);
    endtask

    task automatic drain(input logic [63:0] es, input logic [63:0] eu, input int mode, input int max_hs);
        int k, cyc;
        logic rdy, prev_stall, prev_last;
        logic [7:0] prev_s, prev_u;
        logic [5:0] pat;
        k = 0; cyc = 0; prev_stall = 1'b0; prev_last = 1'b0; prev_s = '0; prev_u = '0;
        pat = 6'b101001;
        while (k < max_hs && cyc < 300) begin
            @(negedge clk);
            chk("drain_flags", {28'd0, s_OutValid, u_OutValid, s_InReady, u_InReady}, 32'hC);
            if (prev_stall)
                chk("hold", {15'd0, s_OutLast, s_SortOut, u_SortOut}, {15'd0, prev_last, prev_s, prev_u});
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[cyc % 6];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            cyc++;
            OutReady = rdy;
            if (rdy) begin
                chk("sorted_s", {24'd0, s_SortOut}, {24'd0, es[k*8 +: 8]});
                chk("sorted_u", {24'd0, u_SortOut}, {24'd0, eu[k*8 +: 8]});
                chk("out_last", {30'd0, s_OutLast, u_OutLast}, (k == N - 1) ? 32'd3 : 32'd0);
                k++;
            end
            prev_stall = ~rdy; prev_s = s_SortOut; prev_u = u_SortOut; prev_last = s_OutLast;
        end
        chk("handshakes", k, max_hs);
        @(posedge clk); #1;
        OutReady = 1'b0;
    endtask

    task automatic run_block(input logic [63:0] v, input logic desc, input int mode, input logic junk,
                             input logic [63:0] es, input logic [63:0] eu);
        int e0s, e0u;
        e0s = err_s; e0u = err_u;
        send_block(v, desc);
        wait_valid(junk);
        drain(es, eu, mode, N);
        chk("no_err_drop", err_s - e0s + err_u - e0u, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] v, v1, v3;
        logic d;
        int e0s, e0u;

        v1 = pack8(8'h05, 8'hFD, 8'h7F, 8'h00, 8'h80, 8'h07, 8'h07, 8'hFF);
        v3 = pack8(8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'h80, 8'h02);
        vecs[0] = '{v: v1, desc: 1'b0, mode: 2'd0, junk: 1'b0,
                    es: pack8(8'h80, 8'hFD, 8'hFF, 8'h00, 8'h05, 8'h07, 8'h07, 8'h7F),
                    eu: pack8(8'h00, 8'h05, 8'h07, 8'h07, 8'h7F, 8'h80, 8'hFD, 8'hFF)};
        vecs[1] = '{v: v1, desc: 1'b1, mode: 2'd0, junk: 1'b0,
                    es: pack8(8'h7F, 8'h07, 8'h07, 8'h05, 8'h00, 8'hFF, 8'hFD, 8'h80),
                    eu: pack8(8'hFF, 8'hFD, 8'h80, 8'h7F, 8'h07, 8'h07, 8'h05, 8'h00)};
        vecs[2] = '{v: v1, desc: 1'b0, mode: 2'd1, junk: 1'b0,
                    es: pack8(8'h80, 8'hFD, 8'hFF, 8'h00, 8'h05, 8'h07, 8'h07, 8'h7F),
                    eu: pack8(8'h00, 8'h05, 8'h07, 8'h07, 8'h7F, 8'h80, 8'hFD, 8'hFF)};
        vecs[3] = '{v: v3, desc: 1'b0, mode: 2'd1, junk: 1'b1,
                    es: pack8(8'h80, 8'h80, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h7F),
                    eu: pack8(8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h80, 8'hFE, 8'hFF)};
        vecs[4] = '{v: v3, desc: 1'b1, mode: 2'd0, junk: 1'b0,
                    es: pack8(8'h7F, 8'h02, 8'h01, 8'h00, 8'hFF, 8'hFE, 8'h80, 8'h80),
                    eu: pack8(8'hFF, 8'hFE, 8'h80, 8'h80, 8'h7F, 8'h02, 8'h01, 8'h00)};

        rst = 1'b1; BlkIn = 1'b0; InValid = 1'b0; Desc = 1'b0; OutReady = 1'b0; InData = '0;
        #1;
        chk("in_ready_in_reset", {30'd0, s_InReady, u_InReady}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_flags", {26'd0, s_OutValid, s_OutLast, s_ErrDrop, s_Busy, u_OutValid, u_Busy}, 32'd0);
        chk("reset_sortout", {16'd0, s_SortOut, u_SortOut}, 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", {30'd0, s_InReady, u_InReady}, 32'd3);

        for (int i = 0; i < 5; i++)
            run_block(vecs[i].v, vecs[i].desc, int'(vecs[i].mode), vecs[i].junk, vecs[i].es, vecs[i].eu);

        // Restart: a second BlkIn beat discards the partial block and re-latches Desc.
        e0s = err_s; e0u = err_u;
        send_beat(1'b1, 32'h04030201, 1'b1);
        send_beat(1'b1, 32'h09090909, 1'b0);
        send_beat(1'b0, 32'h00000000, 1'b1);
        wait_valid(1'b0);
        drain(pack8(0, 0, 0, 0, 9, 9, 9, 9), pack8(0, 0, 0, 0, 9, 9, 9, 9), 0, N);
        chk("restart_err_s", err_s - e0s, 1);
        chk("restart_err_u", err_u - e0u, 1);

        // Stray beat in IDLE.
        e0s = err_s; e0u = err_u;
        send_beat(1'b0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        chk("stray_pulse_idle", {28'd0, s_ErrDrop, u_ErrDrop, s_Busy, u_Busy}, 32'hC);
        @(posedge clk); #1;
        chk("stray_err_count", (err_s - e0s) + (err_u - e0u), 2);

        // Reset during DRAIN after three outputs.
        v = {$urandom, $urandom}; d = 1'($urandom);
        send_block(v, d);
        wait_valid(1'b0);
        drain(model_sort(v, d, 1'b1), model_sort(v, d, 1'b0), 1, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset_flags", {26'd0, s_OutValid, s_OutLast, s_Busy, s_InReady, u_OutValid, u_InReady}, 32'd0);
        chk("mid_reset_sortout", {16'd0, s_SortOut, u_SortOut}, 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_mid_reset", {30'd0, s_InReady, u_InReady}, 32'd3);
        v = {$urandom, $urandom}; d = 1'($urandom);
        run_block(v, d, 0, 1'b0, model_sort(v, d, 1'b1), model_sort(v, d, 1'b0));

        for (int b = 0; b < 20; b++) begin
            v = {$urandom, $urandom};
            if (b % 4 == 0) v[63:32] = v[31:0];
            d = 1'($urandom);
            run_block(v, d, 2, 1'($urandom), model_sort(v, d, 1'b1), model_sort(v, d, 1'b0));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
